// File: rtl/clkdiv_if.sv
// clkdiv_if: carries the divided square wave from the divider to its UART consumers.
interface clkdiv_if;
    logic slow_clk;
    modport master (output slow_clk);
    modport slave  (input  slow_clk);
endinterface

// File: rtl/clkdiv.sv
// clkdiv: integer divider producing a registered, glitch-free fast_clk/DIVISOR square wave.
module clkdiv #(
    parameter int DIVISOR = 4,
    parameter int CNT_W   = $clog2(DIVISOR)
) (
    input  logic     fast_clk,
    input  logic     rst,
    clkdiv_if.master o_bus
);
    localparam int LOW = DIVISOR / 2;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] C_RISE = CNT_W'(LOW - 1);
    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("clkdiv: DIVISOR must be >= 2");
        end
    endgenerate
    logic [CNT_W-1:0] r_cnt;
    logic             r_slow;
    logic             w_last;
    logic             w_rise;
    assign w_last = (r_cnt == C_LAST);
    assign w_rise = (r_cnt == C_RISE);
    // Output decisions use the pre-update count so the edge lands on the wrap/rise cycle.
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_slow <= 1'b0;
        end else begin
            r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
            r_slow <= w_last ? 1'b0 : (w_rise ? 1'b1 : r_slow);
        end
    end
    assign o_bus.slow_clk = r_slow;
endmodule

// File: tb/tb_clkdiv.sv
// tb_clkdiv: directed checks of clkdiv at DIVISOR 4, 5, 2 and 6 sharing one clock and reset.
`timescale 1ns/1ns
module tb_clkdiv;
    logic fast_clk;
    logic rst;
    int   vectors;
    int   miscompares;
    clkdiv_if if4 ();
    clkdiv_if if5 ();
    clkdiv_if if2 ();
    clkdiv_if if6 ();
    clkdiv #(.DIVISOR(4)) dut4 (.fast_clk(fast_clk), .rst(rst), .o_bus(if4));
    clkdiv #(.DIVISOR(5)) dut5 (.fast_clk(fast_clk), .rst(rst), .o_bus(if5));
    clkdiv #(.DIVISOR(2)) dut2 (.fast_clk(fast_clk), .rst(rst), .o_bus(if2));
    clkdiv #(.DIVISOR(6)) dut6 (.fast_clk(fast_clk), .rst(rst), .o_bus(if6));
    initial fast_clk = 1'b0;
    always #25 fast_clk = ~fast_clk;
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask
    // Edge n after release: output high while n mod D sits in the upper HIGH slots.
    function automatic logic exp_slow(input int n, input int d);
        return (n % d) >= (d / 2);
    endfunction
    task automatic chk_all(input int n, input string ph);
        chk($sformatf("%s d4 slow n=%0d", ph, n), 8'(if4.slow_clk), 8'(exp_slow(n, 4)));
        chk($sformatf("%s d5 slow n=%0d", ph, n), 8'(if5.slow_clk), 8'(exp_slow(n, 5)));
        chk($sformatf("%s d2 slow n=%0d", ph, n), 8'(if2.slow_clk), 8'(exp_slow(n, 2)));
        chk($sformatf("%s d6 slow n=%0d", ph, n), 8'(if6.slow_clk), 8'(exp_slow(n, 6)));
        chk($sformatf("%s d4 cnt n=%0d", ph, n), 8'(dut4.r_cnt), 8'(n % 4));
        chk($sformatf("%s d5 cnt n=%0d", ph, n), 8'(dut5.r_cnt), 8'(n % 5));
        chk($sformatf("%s d2 cnt n=%0d", ph, n), 8'(dut2.r_cnt), 8'(n % 2));
        chk($sformatf("%s d6 cnt n=%0d", ph, n), 8'(dut6.r_cnt), 8'(n % 6));
    endtask
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        tick();
        chk_all(0, "rst25");
        tick();
        chk_all(0, "rst75");
        rst = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            chk_all(n, "run");
            if (n == 1) chk("d4 low at 126ns", 8'(if4.slow_clk), 8'd0);
            if (n == 2) chk("d4 rise at 175ns", 8'($time == 176 && if4.slow_clk === 1'b1), 8'd1);
            if (n == 4) chk("d4 fall at 275ns", 8'($time == 276 && if4.slow_clk === 1'b0), 8'd1);
            if (n == 6) chk("d4 rise at 375ns", 8'($time == 376 && if4.slow_clk === 1'b1), 8'd1);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all(0, "hold");
        end
        rst = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk_all(n, "pre");
        end
        chk("d4 high before pulse", 8'(if4.slow_clk), 8'd1);
        rst = 1'b1;
        tick();
        chk_all(0, "pulse");
        rst = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            chk_all(n, "restart");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
